// File: rtl/grndrec.sv
// grndrec: UART-style serial receiver, 16x oversampled.
// Frame: 1 start bit, 8 data bits (LSB first), 1 parity bit, 1 stop bit.
// Each bit is sampled once, in the middle of its bit period.
//
// Ports:
//   Bclkx16_      in   sole clock, 16x the baud rate
//   rst           in   asynchronous reset, active-low
//   clk           in   bit-rate reference, kept for integration only (unused)
//   Rx            in   serial line, idle high, asynchronous to Bclkx16_
//   parity        in   parity mode (0 even, 1 odd), used at the stop-bit sample
//   Rx_err        out  framing error of the last completed frame
//   parity_error  out  parity mismatch of the last completed frame
//   data          out  data byte of the last completed frame
module grndrec (
  input  logic       Bclkx16_,
  input  logic       rst,
  input  logic       clk,
  input  logic       Rx,
  input  logic       parity,
  output logic       Rx_err,
  output logic       parity_error,
  output logic [7:0] data
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  // The bit-rate reference is carried through for the integrator only.
  logic unused_clk;
  assign unused_clk = clk;

  logic       rx_s1_q, rx_s1_d;
  logic       rx_s2_q, rx_s2_d;
  logic [2:0] state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       par_bit_q, par_bit_d;
  logic [7:0] data_q, data_d;
  logic       rx_err_q, rx_err_d;
  logic       par_err_q, par_err_d;

  logic       rx;
  assign rx = rx_s2_q;

  always_comb begin
    rx_s1_d   = Rx;
    rx_s2_d   = rx_s1_q;
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    data_d    = data_q;
    rx_err_d  = rx_err_q;
    par_err_d = par_err_q;

    case (state_q)
      IDLE: begin
        if (!rx) begin
          state_d = START;
          tick_d  = 4'd0;
        end
      end

      // Confirm the start bit at its middle; a high line here is a glitch.
      START: begin
        if (tick_q == 4'd7) begin
          if (!rx) begin
            state_d = DATA;
            tick_d  = 4'd0;
            bit_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tick_d = tick_q + 4'd1;
        end
      end

      // From here on tick 15 falls on the middle of each bit period;
      // the counter wraps to 0 on its own.
      DATA: begin
        tick_d = tick_q + 4'd1;
        if (tick_q == 4'd15) begin
          shift_d = {rx, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = PAR;
          end
        end
      end

      PAR: begin
        tick_d = tick_q + 4'd1;
        if (tick_q == 4'd15) begin
          par_bit_d = rx;
          state_d   = STOP;
        end
      end

      // Leave at mid-stop so a start bit directly after the stop bit is caught.
      STOP: begin
        tick_d = tick_q + 4'd1;
        if (tick_q == 4'd15) begin
          data_d    = shift_q;
          rx_err_d  = ~rx;
          par_err_d = (^shift_q ^ parity) != par_bit_q;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Bclkx16_ or negedge rst) begin
    if (!rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      state_q   <= IDLE;
      tick_q    <= 4'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      par_bit_q <= 1'b0;
      data_q    <= 8'h00;
      rx_err_q  <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      rx_s1_q   <= rx_s1_d;
      rx_s2_q   <= rx_s2_d;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      data_q    <= data_d;
      rx_err_q  <= rx_err_d;
      par_err_q <= par_err_d;
    end
  end

  assign data         = data_q;
  assign Rx_err       = rx_err_q;
  assign parity_error = par_err_q;

endmodule

// File: tb/tb_grndrec.sv
// tb_grndrec: bench for grndrec. Frames are driven tick by tick on the
// 16x clock; expected outputs come from a frame-level model (byte value,
// parity rule, stop-bit rule, fixed update latency).
module tb_grndrec;

  logic       bclk;
  logic       clk;
  logic       rst;
  logic       Rx;
  logic       parity;
  logic       Rx_err;
  logic       parity_error;
  logic [7:0] data;

  int tests;
  int fails;

  logic [7:0] exp_data;
  logic       exp_rerr;
  logic       exp_perr;

  grndrec dut (
    .Bclkx16_    (bclk),
    .rst         (rst),
    .clk         (clk),
    .Rx          (Rx),
    .parity      (parity),
    .Rx_err      (Rx_err),
    .parity_error(parity_error),
    .data        (data)
  );

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;
  initial clk = 1'b0;
  always #80 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_data"}, {24'h0, data}, {24'h0, exp_data});
    chk({tag, "_rerr"}, {31'h0, Rx_err}, {31'h0, exp_rerr});
    chk({tag, "_perr"}, {31'h0, parity_error}, {31'h0, exp_perr});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge bclk);
      Rx = 1'b1;
    end
  endtask

  // Drives one frame; bit i of the frame occupies ticks 16*i+1 .. 16*i+16.
  // Raw start edge before tick 1 -> two synchronizer ticks, then the
  // 168-tick receive latency, so outputs update on tick 171.
  // rst_at != 0 pulses reset at that tick and abandons the frame.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb,
                            input logic pmode, input logic glitch, input int rst_at);
    logic [10:0] fb;
    logic [7:0]  nd;
    logic        ne;
    logic        np;
    logic        b;
    int          i;
    int          off;
    fb = {stopb, pbit, d, 1'b0};
    nd = d;
    ne = ~stopb;
    np = ((^d) ^ pmode) != pbit;
    parity = pmode;
    for (int n = 1; n <= 176; n++) begin
      i   = (n - 1) / 16;
      off = (n - 1) % 16 + 1;
      @(negedge bclk);
      if (rst_at != 0 && n >= rst_at) begin
        Rx = 1'b1;
        if (n == rst_at) begin
          rst = 1'b0;
          #1;
          exp_data = 8'h00;
          exp_rerr = 1'b0;
          exp_perr = 1'b0;
          chk_outs("rst_now");
        end
        if (n == rst_at + 3) rst = 1'b1;
      end else begin
        b = fb[i];
        // Off-centre glitches in data/parity bits must be ignored.
        if (glitch && i >= 1 && i <= 9 && (off == 3 || off == 14) && $urandom_range(0, 1) == 1)
          b = ~b;
        Rx = b;
      end
      @(posedge bclk);
      #1;
      if (rst_at == 0) begin
        if (n == 170) chk_outs("hold");
        if (n == 171) begin
          exp_data = nd;
          exp_rerr = ne;
          exp_perr = np;
          chk_outs("upd");
        end
      end
    end
    idle(20);
    chk_outs("after");
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b0;
    Rx       = 1'b1;
    parity   = 1'b0;
    exp_data = 8'h00;
    exp_rerr = 1'b0;
    exp_perr = 1'b0;
    repeat (3) @(posedge bclk);
    #1;
    chk_outs("reset");
    @(negedge bclk);
    rst = 1'b1;
    idle(20);

    // Even parity, clean frame.
    send_frame(8'hCF, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    // Framing error: data and parity still updated.
    send_frame(8'hCF, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    // Parity mismatch.
    send_frame(8'hEF, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    // Odd parity, correct and wrong parity bit.
    send_frame(8'hCF, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    send_frame(8'hCF, 1'b0, 1'b1, 1'b1, 1'b0, 0);

    // Short low pulse is a false start; a frame right after must be received.
    for (int k = 1; k <= 16; k++) begin
      @(negedge bclk);
      Rx = (k <= 4) ? 1'b0 : 1'b1;
    end
    idle(24);
    chk_outs("glitch_start");
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 0);

    // Reset in the middle of data bit 4, then a full frame.
    send_frame(8'hCF, 1'b0, 1'b1, 1'b0, 1'b0, 16 * 5 + 8);
    send_frame(8'hCF, 1'b0, 1'b1, 1'b0, 1'b0, 0);

    // Randomized frames with random parity mode, parity bit, stop bit and glitches.
    for (int f = 0; f < 24; f++) begin
      logic [7:0] d;
      logic       pm;
      logic       pb;
      logic       sb;
      d  = 8'($urandom);
      pm = 1'($urandom_range(0, 1));
      pb = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : ((^d) ^ pm);
      sb = ($urandom_range(0, 4) != 0);
      send_frame(d, pb, sb, pm, 1'b1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/grndrec.md
GRNDREC -- requirements
Module: grndrec

Interface
REQ-001 Parameters: none; frame format fixed at 1 start, 8 data (LSB first), 1 parity, 1 stop bit; 16 oversample ticks per bit.
REQ-002 Bclkx16_  input  1  sole clock, 16x baud rate, all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 clk  input  1  bit-rate reference kept for integration, equal to Bclkx16_/16; never used as a clock edge; ignored by logic.
REQ-005 Rx  input  1  serial line, idle high, asynchronous to Bclkx16_.
REQ-006 parity  input  1  parity mode: 0 even, 1 odd; sampled at stop-bit sample.
REQ-007 Rx_err  output  1  framing error of last completed frame (stop bit sampled 0).
REQ-008 parity_error  output  1  parity mismatch of last completed frame.
REQ-009 data  output  8  data byte of last completed frame.

Function
REQ-010 Rx SHALL pass a two-flop synchronizer on Bclkx16_; all references to Rx below mean synchronized Rx.
REQ-011 States SHALL be IDLE, START, DATA, PAR, STOP, with a 4-bit tick counter and a 3-bit data-bit counter.
REQ-012 IDLE: Rx low on a tick -> START with tick counter cleared; Rx high -> stay IDLE.
REQ-013 START: at tick 7 after entry (mid start bit), Rx low -> DATA with counter cleared; Rx high -> IDLE (false start, outputs unchanged).
REQ-014 DATA: every 16th tick, Rx is shifted in LSB first; after the 8th bit -> PAR.
REQ-015 PAR: 16 ticks later, Rx is captured as the received parity bit -> STOP.
REQ-016 STOP: 16 ticks later, Rx is sampled as stop bit; on that same edge data, Rx_err and parity_error are all updated; the state machine then returns to IDLE.
REQ-017 Expected parity bit SHALL be XOR of the 8 data bits when parity=0, and its inverse when parity=1; parity_error = received parity bit != expected.
REQ-018 Rx_err SHALL be 1 if the stop bit is 0, else 0; data and parity_error are still updated on a framing error.
REQ-019 Outputs SHALL be registered and hold their values until the next completed frame; a false start or aborted frame leaves them unchanged.
REQ-020 Latency: outputs change on the edge 8+16*10 = 168 ticks after the tick where START is entered (nominally mid-stop bit).
REQ-021 Returning to IDLE at mid-stop SHALL allow a new start bit arriving as early as the end of the stop bit to be received.
REQ-022 Rx changes during a bit period other than at sample points SHALL have no effect; only the mid-bit sample counts.
REQ-023 A line held low after a framing error is treated as a new start bit once in IDLE; no break detection.

Reset
REQ-024 rst low SHALL immediately force IDLE, clear the counters, the shift register and the synchronizer (to 1), and drive data=8'h00, Rx_err=0, parity_error=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no output update; reception resumes with the first start bit after rst returns high.

Verification
REQ-026 parity=0, frame: start 0, bits 1,1,1,1,0,0,1,1, parity 0, stop 1 -> data=8'hCF, Rx_err=0, parity_error=0.
REQ-027 Same frame with stop bit 0, followed by at least one idle-high bit -> data=8'hCF, Rx_err=1, parity_error=0.
REQ-028 parity=0, bits 1,1,1,1,0,1,1,1, parity 0, stop 1 -> data=8'hEF, Rx_err=0, parity_error=1.
REQ-029 parity=1, bits 1,1,1,1,0,0,1,1: parity bit 1 -> no errors, data=8'hCF; parity bit 0 -> parity_error=1.
REQ-030 Rx low pulse of 4 ticks from idle -> no output change; the state machine returns to IDLE before tick 8.
REQ-031 rst pulsed low during data bit 4 of a frame -> outputs 0 immediately; the next full frame 8'hCF is received correctly with no errors.
